// File: rtl/serial_product_collector_pkg.sv
// rtl/serial_product_collector_pkg.sv - shared types and helpers for the serial product collector
package serial_collector_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Bit counter must hold 0..FRAME_LEN, where FRAME_LEN = 2*n
  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/serial_product_collector.sv
// rtl/serial_product_collector.sv - assembles an LSB-first serial product into a parallel word
module serial_product_collector
  import serial_collector_pkg::*;
#(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             bit_valid,
  input  logic             ser_in,
  input  logic             prod_ready,
  input  logic             clear_err,
  output logic [2*N-1:0]   prod_data,
  output logic             prod_valid,
  output logic             busy,
  output logic             overrun,
  output logic             sync_err
);

  localparam int FRAME_LEN = 2 * N;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  state_t               state_q, state_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [FRAME_LEN-1:0] sh_q, sh_n;
  logic                 complete;
  logic                 sync_set;
  logic                 overrun_set;

  // State, bit counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
    end
  end

  // Next-state: only edges with bit_valid advance anything; frame_start mid-frame restarts
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    sh_n     = sh_q;
    complete = 1'b0;
    sync_set = 1'b0;
    if (bit_valid) begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            sh_n    = {ser_in, sh_q[FRAME_LEN-1:1]};
            cnt_n   = CW'(1);
            state_n = COLLECT;
          end
        end
        COLLECT: begin
          sh_n = {ser_in, sh_q[FRAME_LEN-1:1]};
          if (frame_start) begin
            sync_set = 1'b1;
            cnt_n    = CW'(1);
          end else if (cnt_q == LAST_IDX) begin
            complete = 1'b1;
            cnt_n    = '0;
            state_n  = IDLE;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // A completed frame is dropped only when the held word is not being taken at the same edge
  assign overrun_set = complete && prod_valid && !prod_ready;

  // Output word register and valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_data  <= '0;
      prod_valid <= 1'b0;
    end else if (complete && (!prod_valid || prod_ready)) begin
      prod_data  <= sh_n;
      prod_valid <= 1'b1;
    end else if (prod_valid && prod_ready) begin
      prod_valid <= 1'b0;
    end
  end

  // busy mirrors the registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_n == COLLECT);
    end
  end

  // Sticky error flags; a set at the same edge as clear_err wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (overrun_set)    overrun <= 1'b1;
      else if (clear_err) overrun <= 1'b0;
      if (sync_set)       sync_err <= 1'b1;
      else if (clear_err) sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_product_collector.sv
// tb/tb_serial_product_collector.sv - directed self-checking bench for serial_product_collector
module tb_serial_product_collector;

  localparam int N = 4;
  localparam int FL = 2 * N;

  logic          clk;
  logic          rst_n;
  logic          frame_start;
  logic          bit_valid;
  logic          ser_in;
  logic          prod_ready;
  logic          clear_err;
  logic [FL-1:0] prod_data;
  logic          prod_valid;
  logic          busy;
  logic          overrun;
  logic          sync_err;

  int checks;
  int failures;
  int busy_cnt;

  serial_product_collector #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .ser_in      (ser_in),
    .prod_ready  (prod_ready),
    .clear_err   (clear_err),
    .prod_data   (prod_data),
    .prod_valid  (prod_valid),
    .busy        (busy),
    .overrun     (overrun),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are read there too
  task automatic send_bit(input logic fs, input logic b);
    bit_valid   = 1'b1;
    frame_start = fs;
    ser_in      = b;
    @(posedge clk);
    #1;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    ser_in      = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full frame, bit 0 carries frame_start; busy sampled after every bit
  task automatic send_frame(input logic [FL-1:0] val);
    busy_cnt = 0;
    for (int i = 0; i < FL; i++) begin
      send_bit(i == 0, val[i]);
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    logic [FL-1:0] v;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    frame_start = 1'b0;
    bit_valid = 1'b0;
    ser_in = 1'b0;
    prod_ready = 1'b1;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(prod_data), 32'h0);
    check("rst_valid", 32'(prod_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_flags", {30'b0, overrun, sync_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // Basic frame
    send_frame(8'h2A);
    check("basic_data", 32'(prod_data), 32'h2A);
    check("basic_valid", 32'(prod_valid), 32'h1);
    check("basic_busy_cycles", 32'(busy_cnt), 32'd7);
    idle_cycle();
    check("basic_valid_one_cycle", 32'(prod_valid), 32'h0);

    // Stalls after bits 2 and 5
    v = 8'h2A;
    for (int i = 0; i < FL; i++) begin
      send_bit(i == 0, v[i]);
      if (i == 2 || i == 5) begin
        idle_cycle();
        check("stall_busy_hold", 32'(busy), 32'h1);
      end
      if (i == FL - 2) check("stall_not_early", 32'(prod_valid), 32'h0);
    end
    check("stall_data", 32'(prod_data), 32'h2A);
    check("stall_valid", 32'(prod_valid), 32'h1);
    idle_cycle();

    // Backpressure and overrun
    prod_ready = 1'b0;
    send_frame(8'h2A);
    send_frame(8'hFF);
    check("ovr_data_kept", 32'(prod_data), 32'h2A);
    check("ovr_valid", 32'(prod_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    clear_err = 1'b1;
    idle_cycle();
    clear_err = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);
    prod_ready = 1'b1;
    idle_cycle();
    check("ovr_drained", 32'(prod_valid), 32'h0);

    // Simultaneous completion and transfer
    prod_ready = 1'b0;
    send_frame(8'h2A);
    v = 8'h81;
    for (int i = 0; i < FL; i++) begin
      if (i == FL - 1) prod_ready = 1'b1;
      send_bit(i == 0, v[i]);
    end
    check("sim_data", 32'(prod_data), 32'h81);
    check("sim_valid", 32'(prod_valid), 32'h1);
    check("sim_no_ovr", 32'(overrun), 32'h0);
    idle_cycle();
    check("sim_drained", 32'(prod_valid), 32'h0);

    // Resync: frame_start again at bit 3
    v = 8'h2A;
    for (int i = 0; i < 3; i++) send_bit(i == 0, v[i]);
    check("resync_no_err_yet", 32'(sync_err), 32'h0);
    send_frame(8'h5A);
    check("resync_err", 32'(sync_err), 32'h1);
    check("resync_data", 32'(prod_data), 32'h5A);
    check("resync_valid", 32'(prod_valid), 32'h1);

    // Async reset mid-frame, sync_err still set from above
    v = 8'h81;
    for (int i = 0; i < 4; i++) send_bit(i == 0, v[i]);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_data", 32'(prod_data), 32'h0);
    check("arst_valid", 32'(prod_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_flags", {30'b0, overrun, sync_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    send_frame(8'h3C);
    check("post_rst_data", 32'(prod_data), 32'h3C);
    check("post_rst_valid", 32'(prod_valid), 32'h1);
    check("post_rst_flags", {30'b0, overrun, sync_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
